piano_voice_sched: RTL and testbench
====================================

// Module: piano_voice_sched
// PURPOSE
//   Polyphonic voice scheduler for the piano: samples the 8 key inputs once per audio
//   sample period, time-multiplexes one shared 8-bit waveform ROM across all pressed keys,
//   accumulates their samples and emits one mixed 8-bit sample per period.
//   Replaces per-note ROM copies; sits between key inputs, the wave ROM and the DAC output.
// PARAMETERS
//   NKEYS      8     number of keys/voices
//   PHASE_W    16    per-voice phase accumulator width
//   ROM_AW     8     ROM address width; address = phase[PHASE_W-1 -: ROM_AW]
//   SAMPLE_DIV 256   clk cycles per audio sample; legal range >= NKEYS+5
//   ACC_W      11    mix accumulator width = 8 + clog2(NKEYS)
// PORTS
//   clk          in   1        system clock, all logic on posedge
//   rst          in   1        synchronous, active-high reset
//   keys         in   NKEYS    key levels, bit i = note i (1 = pressed)
//   rom_en       out  1        ROM read strobe
//   rom_addr     out  ROM_AW   ROM read address
//   rom_data     in   8        ROM read data, valid exactly 1 cycle after rom_en
//   wave         out  8        mixed output sample, held between updates
//   sample_valid out  1        1-cycle pulse when wave updates
//   active       out  NKEYS    chord latched for the current sample period
//   busy         out  1        high in every state except IDLE
// BEHAVIOUR
//   Reset: wave=0, sample_valid=0, rom_en=0, rom_addr=0, active=0, busy=0, all phases=0,
//     divider=0, acc=0, state=IDLE. rst overrides everything; mid-sequence rst aborts, no pulse.
//   Divider counts 0..SAMPLE_DIV-1, wraps; tick = (div==SAMPLE_DIV-1).
//   FSM: IDLE -> SCAN -> DRAIN -> OUT -> IDLE.
//   IDLE: on tick: active<=keys, idx<=0, acc<=0, state<=SCAN. keys ignored elsewhere.
//   SCAN (NKEYS cycles, idx 0..NKEYS-1): if active[idx]: rom_en<=1,
//     rom_addr<=phase[idx] top ROM_AW bits, phase[idx]<=phase[idx]+NOTE_INC[idx] (mod 2^PHASE_W);
//     else rom_en<=0, phase[idx]<=0 (released note restarts at phase 0). Last idx -> DRAIN.
//   Accumulate: one cycle after rom_en observed high at ROM, acc<=acc+rom_data (unsigned,
//     ACC_W bits, cannot overflow for NKEYS<=8).
//   DRAIN: 2 cycles, rom_en=0, lets last read land in acc. -> OUT.
//   OUT: wave<=mix(acc), sample_valid<=1 for exactly this update; -> IDLE.
//   Latency: wave/sample_valid update NKEYS+4 clk edges after tick edge; one update per period.
//   No keys pressed: ROM never read, wave<=0, pulse still issued.
//   tick cannot occur outside IDLE given SAMPLE_DIV constraint; if it does, it is ignored.
// CONFIGURATION
//   PIANO_MIX_SHIFT_EN defined: mix(acc) = acc >> clog2(NKEYS) (fixed scaling, never clips).
//   Undefined (default): mix(acc) = (acc > 255) ? 8'hFF : acc[7:0] (saturating).
// STRUCTURE
//   piano_pkg: NOTE_INC[NKEYS] phase-increment table (note pitches), FSM state enum,
//     clog2 helper constant.
//   Sub-module piano_mix_sat: combinational acc -> 8-bit mix, holds the macro switch.
//   Phase array, divider, FSM and accumulator stay in piano_voice_sched.
// TESTING (ROM model: 1-cycle latency, programmable data)
//   rst high 2 cycles mid-SCAN -> next cycle wave=0, rom_en=0, active=0, busy=0, no pulse.
//   keys=0, run 3 periods -> rom_en never 1, sample_valid pulses every 256 clks, wave=0.
//   keys=8'h01, ROM data=8'h80 -> wave=8'h80 (default); 8'h10 with PIANO_MIX_SHIFT_EN.
//   keys=8'hFF, ROM data=8'h40 -> acc=0x200, wave=8'hFF (default); 8'h40 with macro.
//   keys=8'h08, NOTE_INC[3]=16'h0100 -> rom_addr 0,1,2,3 on successive periods;
//     release 1 period then re-press -> rom_addr restarts at 0.
//   keys change mid-period -> active and wave reflect only value at tick; pulse at tick+NKEYS+4.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the piano voice scheduler: sizing constants,
// FSM state encoding and the per-note phase-increment table.
package piano_pkg;

  localparam int NKEYS      = 8;
  localparam int PHASE_W    = 16;
  localparam int ROM_AW     = 8;
  localparam int SAMPLE_DIV = 256;
  localparam int MIX_SHIFT  = $clog2(NKEYS);
  localparam int ACC_W      = 8 + MIX_SHIFT;
  localparam int IDX_W      = $clog2(NKEYS);
  localparam int DIV_W      = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Phase increment per audio sample for each key (sets the note pitch).
  function automatic logic [PHASE_W-1:0] note_inc(input logic [IDX_W-1:0] i);
    logic [PHASE_W-1:0] r;
    r = '0;
    case (i)
      3'd0: r = 16'h00B2;
      3'd1: r = 16'h00C8;
      3'd2: r = 16'h00E1;
      3'd3: r = 16'h0100;
      3'd4: r = 16'h0110;
      3'd5: r = 16'h0131;
      3'd6: r = 16'h0155;
      3'd7: r = 16'h0165;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/piano_mix_sat.sv
// Combinational mix stage: folds the wide voice accumulator into one 8-bit
// output sample. Macro PIANO_MIX_SHIFT_EN selects fixed down-scaling by
// clog2(NKEYS); without it the sum saturates at 8'hFF.
module piano_mix_sat
  import piano_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  output logic [7:0]       mix
);

`ifdef PIANO_MIX_SHIFT_EN
  // Fixed scaling: the top 8 bits of the accumulator, never clips.
  always_comb begin
    mix = acc[MIX_SHIFT +: 8];
  end
`else
  // Saturating: anything above full scale is clamped.
  always_comb begin
    mix = (acc > ACC_W'(255)) ? 8'hFF : acc[7:0];
  end
`endif

endmodule

// File: rtl/piano_voice_sched.sv
// Polyphonic voice scheduler. Once per audio sample period it latches the
// chord, walks every key, issues one shared-ROM read per pressed key,
// sums the returned samples and emits one mixed sample.
// Build option: PIANO_MIX_SHIFT_EN (see piano_mix_sat).
//
// Interface timing: rom_en is a one-cycle read strobe with rom_addr valid in
// the same cycle; rom_data is taken exactly one cycle after the ROM sees
// rom_en high (there is no back-pressure). sample_valid is a one-cycle pulse
// that marks the cycle in which wave first carries the new sample; wave holds
// its value until the next pulse.
module piano_voice_sched
  import piano_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NKEYS-1:0]  keys,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        wave,
  output logic              sample_valid,
  output logic [NKEYS-1:0]  active,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  state_t             state;
  state_t             state_nxt;
  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [IDX_W-1:0]   idx;
  logic               drain_cnt;
  logic               rd_pend;
  logic [ACC_W-1:0]   acc;
  logic [7:0]         mix_val;
  logic [PHASE_W-1:0] phase [NKEYS];

  assign tick      = (div == DIV_W'(SAMPLE_DIV - 1));
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  piano_mix_sat u_mix (
    .acc (acc),
    .mix (mix_val)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> SCAN (NKEYS cycles) -> DRAIN (2 cycles) -> OUT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (tick) state_nxt = ST_SCAN;
      ST_SCAN:  if (idx == IDX_W'(NKEYS - 1)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) state_nxt = ST_OUT;
      ST_OUT:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: sample divider, ROM read issue, phase update, accumulation, output.
  always_ff @(posedge clk) begin
    if (rst) begin
      div          <= '0;
      idx          <= '0;
      drain_cnt    <= 1'b0;
      rd_pend      <= 1'b0;
      acc          <= '0;
      active       <= '0;
      rom_en       <= 1'b0;
      rom_addr     <= '0;
      wave         <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < NKEYS; i++) phase[i] <= '0;
    end else begin
      div          <= tick ? '0 : div + 1'b1;
      // rd_pend marks the cycle in which the ROM returns data for a strobe.
      rd_pend      <= rom_en;
      rom_en       <= 1'b0;
      sample_valid <= 1'b0;
      if (rd_pend) acc <= acc + ACC_W'(rom_data);
      case (state)
        ST_IDLE: begin
          if (tick) begin
            active    <= keys;
            idx       <= '0;
            acc       <= '0;
            drain_cnt <= 1'b0;
          end
        end
        ST_SCAN: begin
          idx <= idx + 1'b1;
          if (active[idx]) begin
            rom_en     <= 1'b1;
            rom_addr   <= phase[idx][PHASE_W-1 -: ROM_AW];
            phase[idx] <= phase[idx] + note_inc(idx);
          end else begin
            // A released note restarts from phase 0 on its next press.
            phase[idx] <= '0;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
        end
        ST_OUT: begin
          wave         <= mix_val;
          sample_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piano_voice_sched.sv
// Directed bench for piano_voice_sched with a one-cycle-latency ROM model
// and a scoreboard of expected samples.
module tb_piano_voice_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] keys;
  logic       rom_en;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] wave;
  logic       sample_valid;
  logic [7:0] active;
  logic       busy;
  logic [1:0] dbg_state;

  logic [7:0] rom_val = 8'h00;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         pulse_cnt = 0;
  int         exp_pulses = 0;
  int         rd_cnt = 0;
  logic       track_addr = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_act_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] exp_addr_q[$];

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ROM model: data appears one cycle after the strobe
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_val;
  end

  piano_voice_sched dut (
    .clk          (clk),
    .rst          (rst),
    .keys         (keys),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .wave         (wave),
    .sample_valid (sample_valid),
    .active       (active),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_mix(input int n, input logic [7:0] v);
    int a;
    a = n * int'(v);
`ifdef PIANO_MIX_SHIFT_EN
    return 8'(a >> 3);
`else
    return (a > 255) ? 8'hFF : 8'(a);
`endif
  endfunction

  // driver: wait (bounded) for a given position inside the sample period
  task automatic sync_to(input int ph);
    int n;
    n = 0;
    @(negedge clk);
    while ((cyc % 256) != ph && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) check("sync_timeout", 32'(cyc), 32'(ph));
  endtask

  task automatic push_exp(input logic [7:0] k, input logic [7:0] v);
    exp_q.push_back(exp_mix($countones(k), v));
    exp_act_q.push_back(k);
    exp_rd_q.push_back(8'($countones(k)));
    exp_pulses++;
  endtask

  task automatic wait_pulses();
    int n;
    n = 0;
    while (pulse_cnt < exp_pulses && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1200) check("pulse_timeout", 32'(pulse_cnt), 32'(exp_pulses));
  endtask

  task automatic run_period(input logic [7:0] k, input logic [7:0] v);
    sync_to(100);
    keys    = k;
    rom_val = v;
    push_exp(k, v);
    wait_pulses();
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst) begin
      rd_cnt = 0;
    end else begin
      if (rom_en) begin
        rd_cnt++;
        if (track_addr) begin
          if (exp_addr_q.size() == 0) check("unexpected_read", 32'(rom_addr), 32'hFFFF);
          else check("rom_addr", 32'(rom_addr), 32'(exp_addr_q.pop_front()));
        end
      end
      if (sample_valid) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(wave), 32'hFFFF);
        end else begin
          check("wave", 32'(wave), 32'(exp_q.pop_front()));
          check("active", 32'(active), 32'(exp_act_q.pop_front()));
          check("rom_reads", 32'(rd_cnt), 32'(exp_rd_q.pop_front()));
          check("pulse_phase", 32'(cyc % 256), 32'd11);
        end
        rd_cnt = 0;
      end
    end
  end

  initial begin
    rst  = 1'b1;
    keys = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_wave", 32'(wave), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_rom_en", 32'(rom_en), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // silence: no reads, zero output, pulse every period
    run_period(8'h00, 8'h55);
    run_period(8'h00, 8'h55);
    run_period(8'h00, 8'h55);

    // single voice and full chord
    run_period(8'h01, 8'h80);
    run_period(8'hFF, 8'h40);
    run_period(8'h00, 8'h40);

    // phase stepping of key 3, release, re-press
    track_addr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(8'(i));
      run_period(8'h08, 8'h11);
    end
    run_period(8'h00, 8'h11);
    exp_addr_q.push_back(8'h00);
    run_period(8'h08, 8'h11);
    track_addr = 1'b0;
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);

    // keys changing mid-period only take effect at the next tick
    sync_to(200);
    keys    = 8'h03;
    rom_val = 8'h30;
    push_exp(8'h03, 8'h30);
    sync_to(3);
    keys = 8'hF0;
    push_exp(8'hF0, 8'h30);
    sync_to(5);
    check("active_mid_scan", 32'(active), 32'h03);
    wait_pulses();

    // reset in the middle of SCAN aborts the period without a pulse
    sync_to(100);
    keys    = 8'hFF;
    rom_val = 8'h10;
    sync_to(4);
    check("busy_in_scan", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_wave", 32'(wave), 32'h0);
    check("abort_rom_en", 32'(rom_en), 32'h0);
    check("abort_active", 32'(active), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_valid", 32'(sample_valid), 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    keys = 8'h00;
    run_period(8'h01, 8'h80);
    check("pulse_total", 32'(pulse_cnt), 32'(exp_pulses));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
